hw_registers_receiver: RTL and testbench
========================================

# hw_registers_receiver

Receive-side counterpart of the shift-register display driver. Samples the serial lines the driver produces (bit clock, active-low register clear, digit and control serial data, register latch clock) in the local clock domain. Rebuilds the 74HC595-style digit and control shift chains and presents the latched contents as parallel words. Used as an on-chip loopback checker and as the front end of an FPGA-emulated display board.

## Interface
Parameters:
- REG_SIZE, 8, bits per shift register
- NUM_DATA_REG, 6, number of chained digit registers
- SYNC_STAGES, 2, synchronizer depth per input (≥2)

Ports:
- clk  in  1  receiver clock; one clock domain
- nrst  in  1  asynchronous, active-low reset
- all_bit_clk  in  1  serial bit clock; shift on rising edge
- all_nrst  in  1  active-low shift-chain clear (level)
- digit_data_ser  in  1  digit chain serial data
- control_data_ser  in  1  control register serial data
- control_reg_clk  in  1  storage latch; latch on rising edge
- dig_data_out  out  [NUM_DATA_REG-1:0][REG_SIZE-1:0]  latched digit data
- ctrl_out  out  [REG_SIZE-1:0]  latched control data
- frame_valid  out  1  one-cycle pulse per latch
- frame_err  out  1  last latched frame had wrong bit count

## Operation
- All five serial inputs pass through SYNC_STAGES flops plus one history flop. Rising edge = synced 1 and history 0. Data lines use the same depth, so data is sampled aligned with its clock.
- Bit edge with synced all_nrst high:
  - digit shift register (NUM_DATA_REG*REG_SIZE bits) shifts left, new bit at bit 0.
  - control shift register (REG_SIZE bits) does the same.
  - bit_cnt increments, saturating at NUM_DATA_REG*REG_SIZE+1.
  - After 48 bits, the first bit shifted is at dig_data_out[5][7].
- Synced all_nrst low: digit shift register, control shift register and bit_cnt are held at 0. Bit edges are ignored. Storage outputs are unaffected.
- Latch edge:
  - dig_data_out and ctrl_out load the shift registers.
  - frame_valid pulses for one cycle.
  - frame_err loads (bit_cnt != NUM_DATA_REG*REG_SIZE).
  - bit_cnt clears.
- Bit edge and latch edge in the same cycle: storage captures the pre-shift contents, as on a 74HC595. The shift still occurs, and bit_cnt becomes 1.
- Latch while all_nrst low: storage loads zeros and frame_err=1, because the count is 0.
- No state machine beyond the counter. frame_err is a level that holds until the next latch.

## Timing
- Reset (nrst low, async): all synchronizer and history flops, both shift registers, bit_cnt, dig_data_out, ctrl_out, frame_valid and frame_err go to 0.
- Input constraint: each serial input holds each level ≥2 clk cycles. Data is stable ≥1 clk before and after its bit clock rising edge.
- Latency from a pin rising edge to its effect, with SYNC_STAGES=2:
  - shift register updated on the 3rd clk edge.
  - dig_data_out, ctrl_out, frame_valid and frame_err change on the 3rd clk edge after the control_reg_clk rise.
- frame_valid is high exactly one cycle per latch edge, even if control_reg_clk stays high.
- Outputs are registered; there are no combinational paths from inputs.

## Structure
- Shared package hw_regs_pkg holds:
  - DIG_BITS = NUM_DATA_REG*REG_SIZE default constant
  - CNT_W = $clog2(DIG_BITS+2)
  - digit word typedef used by both driver and receiver
- Sub-module sync_edge_det (parameter SYNC_STAGES): 1-bit synchronizer with outputs sync_q and rise. Five instances, one per serial input.
- Top: shift registers, bit counter, storage registers, and frame_valid/frame_err logic.

## Test plan
- Reset: drive nrst low mid-frame → all outputs 0 within the same cycle; after release, no frame_valid until a latch edge.
- Nominal frame: shift 48'h41_49_99_0D_25_9F MSB-first, control 8'h01, then latch → dig_data_out=48'h41_49_99_0D_25_9F, ctrl_out=8'h01, one frame_valid pulse, frame_err=0.
- Back-to-back frames: follow with 48'h63_C1_11_09_01_1F / 8'h02 → outputs update only at the second latch; first value is held while shifting.
- Short frame: 40 bits then latch → frame_err=1; low 40 bits of the chain are reflected in dig_data_out[4:0], dig_data_out[5]=0 when preceded by all_nrst.
- Clear: pulse all_nrst low after 20 bits, then shift 48 bits and latch → correct word, frame_err=0. Latch while all_nrst low → zeros, frame_err=1.
- Coincident edges: bit clock and control_reg_clk rise in the same clk → storage holds pre-shift value, next frame's bit_cnt starts at 1 (47 more bits give frame_err=0).

Source files
------------

// File: rtl/hw_regs_pkg.sv
// Shared constants and types for the shift-register display driver and its receiver.
package hw_regs_pkg;

    localparam int REG_SIZE_DEF     = 8;
    localparam int NUM_DATA_REG_DEF = 6;
    localparam int DIG_BITS         = NUM_DATA_REG_DEF * REG_SIZE_DEF;
    localparam int CNT_W            = $clog2(DIG_BITS + 2);

    typedef logic [REG_SIZE_DEF-1:0] digit_t;

    // Counter width able to hold every count up to bits+1 (the saturation value).
    function automatic int cnt_width(input int bits);
        return $clog2(bits + 2);
    endfunction

endpackage

// File: rtl/hw_registers_receiver_sync.sv
// One-bit synchronizer with a history flop; rise pulses for one cycle per synced 0->1.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic nrst,
    input  logic pin,
    output logic sync_q,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_p;
    logic                   hist;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_p <= '0;
            hist   <= 1'b0;
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], pin};
            hist   <= sync_p[SYNC_STAGES-1];
        end
    end

    assign sync_q = sync_p[SYNC_STAGES-1];
    assign rise   = sync_q & ~hist;

endmodule

// File: rtl/hw_registers_receiver.sv
// Rebuilds the 74HC595-style digit and control chains from the driver's serial lines.
module hw_registers_receiver
    import hw_regs_pkg::*;
#(
    parameter int REG_SIZE     = REG_SIZE_DEF,
    parameter int NUM_DATA_REG = NUM_DATA_REG_DEF,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                                   clk,
    input  logic                                   nrst,
    input  logic                                   all_bit_clk,
    input  logic                                   all_nrst,
    input  logic                                   digit_data_ser,
    input  logic                                   control_data_ser,
    input  logic                                   control_reg_clk,
    output logic [NUM_DATA_REG-1:0][REG_SIZE-1:0]  dig_data_out,
    output logic [REG_SIZE-1:0]                    ctrl_out,
    output logic                                   frame_valid,
    output logic                                   frame_err
);

    localparam int             BITS     = NUM_DATA_REG * REG_SIZE;
    localparam int             CW       = cnt_width(BITS);
    localparam logic [CW-1:0]  CNT_FULL = CW'(BITS);
    localparam logic [CW-1:0]  CNT_SAT  = CW'(BITS + 1);

    logic [4:0] pins;
    logic [4:0] sync_vec;
    logic [4:0] rise_vec;
    logic [4:0] unused_bits;

    assign pins = {control_reg_clk, control_data_ser, digit_data_ser, all_nrst, all_bit_clk};

    // Data lines share the clock lines' depth so data arrives aligned with its edge.
    for (genvar g = 0; g < 5; g++) begin : g_sync
        sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk    (clk),
            .nrst   (nrst),
            .pin    (pins[g]),
            .sync_q (sync_vec[g]),
            .rise   (rise_vec[g])
        );
    end

    logic bit_rise, chain_en, dig_bit, ctrl_bit, latch_rise;

    assign bit_rise    = rise_vec[0];
    assign chain_en    = sync_vec[1];
    assign dig_bit     = sync_vec[2];
    assign ctrl_bit    = sync_vec[3];
    assign latch_rise  = rise_vec[4];
    assign unused_bits = {rise_vec[3:1], sync_vec[4], sync_vec[0]};

    logic [BITS-1:0]     dig_sr;
    logic [REG_SIZE-1:0] ctrl_sr;
    logic [CW-1:0]       bit_cnt;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            dig_sr  <= '0;
            ctrl_sr <= '0;
            bit_cnt <= '0;
        end else if (!chain_en) begin
            dig_sr  <= '0;
            ctrl_sr <= '0;
            bit_cnt <= '0;
        end else if (bit_rise) begin
            dig_sr  <= {dig_sr[BITS-2:0], dig_bit};
            ctrl_sr <= {ctrl_sr[REG_SIZE-2:0], ctrl_bit};
            // A coincident latch consumes the old count; this bit opens the next frame.
            if (latch_rise)
                bit_cnt <= CW'(1);
            else if (bit_cnt != CNT_SAT)
                bit_cnt <= bit_cnt + CW'(1);
        end else if (latch_rise) begin
            bit_cnt <= '0;
        end
    end

    // Storage samples the pre-shift chain, matching the 74HC595 latch behaviour.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            dig_data_out <= '0;
            ctrl_out     <= '0;
            frame_valid  <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            frame_valid <= latch_rise;
            if (latch_rise) begin
                dig_data_out <= dig_sr;
                ctrl_out     <= ctrl_sr;
                frame_err    <= (bit_cnt != CNT_FULL);
            end
        end
    end

endmodule

// File: tb/tb_hw_registers_receiver.sv
// Self-checking bench: table-driven frames, hand-written corner sequences and random frames.
module tb_hw_registers_receiver;

    logic            clk = 1'b0;
    logic            nrst = 1'b0;
    logic            bclk = 1'b0;
    logic            anrst = 1'b1;
    logic            dser = 1'b0;
    logic            cser = 1'b0;
    logic            lclk = 1'b0;
    logic [5:0][7:0] dig_out;
    logic [7:0]      ctrl;
    logic            fv;
    logic            ferr;

    hw_registers_receiver dut (
        .clk              (clk),
        .nrst             (nrst),
        .all_bit_clk      (bclk),
        .all_nrst         (anrst),
        .digit_data_ser   (dser),
        .control_data_ser (cser),
        .control_reg_clk  (lclk),
        .dig_data_out     (dig_out),
        .ctrl_out         (ctrl),
        .frame_valid      (fv),
        .frame_err        (ferr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int fv_count = 0;

    always @(negedge clk) if (fv === 1'b1) fv_count++;

    // Reference model: every bit accepted since the last chain clear, plus a latch mark.
    bit          dq[$];
    bit          cq[$];
    int          mark = 0;
    logic [47:0] exp_dig = '0;
    logic [7:0]  exp_ctrl = '0;
    logic        exp_err = 1'b0;
    int          exp_fv = 0;

    function automatic logic [63:0] last_bits(input bit q[$], input int n);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++)
            if (q.size() > i) v[i] = q[q.size() - 1 - i];
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_latch();
        int cnt;
        exp_dig  = last_bits(dq, 48);
        exp_ctrl = last_bits(cq, 8);
        cnt      = dq.size() - mark;
        if (cnt > 49) cnt = 49;
        exp_err  = (cnt != 48);
        mark     = dq.size();
        exp_fv++;
    endtask

    task automatic model_clear();
        dq.delete();
        cq.delete();
        mark = 0;
    endtask

    task automatic send_bit(input bit d, input bit c, input bit with_latch);
        dser = d;
        cser = c;
        tick(3);
        bclk = 1'b1;
        if (with_latch) lclk = 1'b1;
        tick(3);
        bclk = 1'b0;
        lclk = 1'b0;
        if (with_latch) model_latch();
        if (anrst) begin
            dq.push_back(d);
            cq.push_back(c);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, " dig"}, 64'(dig_out), 64'(exp_dig));
        chk({tag, " ctrl"}, 64'(ctrl), 64'(exp_ctrl));
        chk({tag, " err"}, 64'(ferr), 64'(exp_err));
        chk({tag, " fv_count"}, 64'(fv_count), 64'(exp_fv));
    endtask

    task automatic send_frame(input logic [47:0] w, input logic [7:0] c, input int n,
                              input bit hold_check);
        for (int i = n - 1; i >= 0; i--) begin
            send_bit((i < 48) ? w[i] : 1'b1, (i < 8) ? c[i] : 1'b0, 1'b0);
            if (hold_check && i == n / 2) check_model("hold");
        end
    endtask

    task automatic latch();
        lclk = 1'b1;
        tick(4);
        lclk = 1'b0;
        tick(4);
        model_latch();
    endtask

    task automatic clear_pulse();
        anrst = 1'b0;
        tick(3);
        model_clear();
        anrst = 1'b1;
        tick(3);
    endtask

    typedef struct {
        bit          pre_clear;
        int          nbits;
        logic [47:0] word;
        logic [7:0]  cw;
        logic [47:0] e_dig;
        logic [7:0]  e_ctrl;
        logic        e_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{0, 48, 48'h41_49_99_0D_25_9F, 8'h01, 48'h41_49_99_0D_25_9F, 8'h01, 1'b0};
        vecs[1] = '{0, 48, 48'h63_C1_11_09_01_1F, 8'h02, 48'h63_C1_11_09_01_1F, 8'h02, 1'b0};
        vecs[2] = '{1, 40, 48'hA5_5A_C3_3C_F0_0F, 8'h81, 48'h00_5A_C3_3C_F0_0F, 8'h81, 1'b1};
        vecs[3] = '{0, 48, 48'h0F_F0_33_CC_55_AA, 8'h3C, 48'h0F_F0_33_CC_55_AA, 8'h3C, 1'b0};
        vecs[4] = '{0, 50, 48'h12_34_56_78_9A_BC, 8'hE7, 48'h12_34_56_78_9A_BC, 8'hE7, 1'b1};
        vecs[5] = '{1, 48, 48'hDE_AD_BE_EF_00_11, 8'h5A, 48'hDE_AD_BE_EF_00_11, 8'h5A, 1'b0};

        tick(3);
        check_model("reset");
        nrst = 1'b1;
        tick(3);

        foreach (vecs[k]) begin
            if (vecs[k].pre_clear) clear_pulse();
            send_frame(vecs[k].word, vecs[k].cw, vecs[k].nbits, 1'b1);
            latch();
            chk($sformatf("vec%0d dig", k), 64'(dig_out), 64'(vecs[k].e_dig));
            chk($sformatf("vec%0d ctrl", k), 64'(ctrl), 64'(vecs[k].e_ctrl));
            chk($sformatf("vec%0d err", k), 64'(ferr), 64'(vecs[k].e_err));
            chk($sformatf("vec%0d fv_count", k), 64'(fv_count), 64'(exp_fv));
        end

        // Latch latency and single-cycle pulse while control_reg_clk stays high.
        lclk = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("lat fv early", 64'(fv), 64'(0));
        @(posedge clk); #1;
        chk("lat fv pulse", 64'(fv), 64'(1));
        @(posedge clk); #1;
        chk("lat fv drop", 64'(fv), 64'(0));
        tick(5);
        lclk = 1'b0;
        tick(4);
        model_latch();
        check_model("relatch");

        // Clear after 20 bits, then a full frame.
        send_frame(48'hFF_FF_FF_FF_FF_FF, 8'hFF, 20, 1'b0);
        clear_pulse();
        send_frame(48'h41_49_99_0D_25_9F, 8'h01, 48, 1'b0);
        latch();
        check_model("clear");
        chk("clear err", 64'(ferr), 64'(0));

        // Latch while the chain is held clear.
        anrst = 1'b0;
        tick(3);
        model_clear();
        latch();
        check_model("latch_in_clear");
        chk("latch_in_clear zero", 64'(dig_out), 64'(0));
        anrst = 1'b1;
        tick(3);

        // Coincident bit and latch edges.
        send_frame(48'h63_C1_11_09_01_1F, 8'h02, 48, 1'b0);
        send_bit(1'b1, 1'b0, 1'b1);
        tick(2);
        check_model("coinc store");
        chk("coinc pre-shift", 64'(dig_out), 64'(48'h63_C1_11_09_01_1F));
        send_frame(48'h0, 8'h0, 47, 1'b0);
        latch();
        check_model("coinc next");
        chk("coinc next err", 64'(ferr), 64'(0));

        for (int r = 0; r < 8; r++) begin
            logic [47:0] w;
            w = {16'($urandom), 32'($urandom)};
            if ($urandom_range(0, 2) == 0) clear_pulse();
            send_frame(w, 8'($urandom), int'($urandom_range(44, 52)), 1'b0);
            latch();
            check_model($sformatf("rand%0d", r));
        end

        // Asynchronous reset mid-frame.
        send_frame(48'hFF_FF_FF_FF_FF_FF, 8'hFF, 20, 1'b0);
        nrst = 1'b0;
        #1;
        model_clear();
        exp_dig  = '0;
        exp_ctrl = '0;
        exp_err  = 1'b0;
        chk("rst dig", 64'(dig_out), 64'(0));
        chk("rst ctrl", 64'(ctrl), 64'(0));
        chk("rst err", 64'(ferr), 64'(0));
        chk("rst fv", 64'(fv), 64'(0));
        tick(2);
        nrst = 1'b1;
        tick(10);
        check_model("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
